// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a one-byte holding register.
// Bytes arrive on a valid/ready handshake. Each frame is a start bit,
// 8 data bits sent LSB first, an optional parity bit and a stop bit.
// Every bit lasts CLKS_PER_BIT clocks.
// Optional even parity is enabled by defining UART_TX_PARITY_EN.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] d_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int unsigned   TW       = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        r_state, w_state;
  logic [TW-1:0] r_timer, w_timer;
  logic [7:0]    r_shift, w_shift;
  logic [2:0]    r_idx, w_idx;
  logic [7:0]    r_hold, w_hold;
  logic          r_hold_full, w_hold_full;
  logic          r_tx, w_tx;
  logic          r_busy, w_busy;
  logic          r_done, w_done;
`ifdef UART_TX_PARITY_EN
  logic          r_par, w_par;
`endif

  logic w_bit_end;
  logic w_accept;
  logic w_bypass;
  logic w_load_hold;

  assign ready_o = ~r_hold_full;
  assign tx_o    = r_tx;
  assign busy_o  = r_busy;
  assign done_o  = r_done;

  // Next-state, bit timing, handshake and line-level decisions.
  always_comb begin
    w_state     = r_state;
    w_shift     = r_shift;
    w_idx       = r_idx;
    w_hold      = r_hold;
    w_hold_full = r_hold_full;
    w_tx        = r_tx;
    w_busy      = r_busy;
    w_done      = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_par       = r_par;
`endif
    w_bit_end   = (r_timer == '0);
    w_accept    = valid_i && !r_hold_full;
    w_bypass    = 1'b0;
    w_load_hold = 1'b0;
    w_timer     = (r_state == IDLE || w_bit_end) ? BIT_LAST : r_timer - TW'(1);

    case (r_state)
      IDLE: begin
        if (r_hold_full) w_load_hold = 1'b1;
        else if (w_accept) w_bypass = 1'b1;
      end
      START: begin
        if (w_bit_end) begin
          w_state = DATA;
          w_tx    = r_shift[0];
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_shift = {1'b0, r_shift[7:1]};
          w_idx   = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state = PARITY;
            w_tx    = r_par;
`else
            w_state = STOP;
            w_tx    = 1'b1;
`endif
          end else begin
            w_tx = r_shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_end) begin
          w_state = STOP;
          w_tx    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (w_bit_end) begin
          w_done = 1'b1;
          if (r_hold_full) w_load_hold = 1'b1;
          else if (w_accept) w_bypass = 1'b1;
          else begin
            w_state = IDLE;
            w_tx    = 1'b1;
            w_busy  = 1'b0;
          end
        end
      end
      default: w_state = IDLE;
    endcase

    // Shared frame launch for both the queued byte and a bypass accept,
    // so a frame can start straight out of STOP with no idle cycle.
    if (w_bypass || w_load_hold) begin
      w_state = START;
      w_tx    = 1'b0;
      w_busy  = 1'b1;
      w_idx   = '0;
      w_shift = w_load_hold ? r_hold : d_i;
`ifdef UART_TX_PARITY_EN
      w_par   = ^w_shift;
`endif
      if (w_load_hold) w_hold_full = 1'b0;
    end

    if (w_accept && !w_bypass) begin
      w_hold      = d_i;
      w_hold_full = 1'b1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_timer     <= BIT_LAST;
      r_shift     <= '0;
      r_idx       <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state;
      r_timer     <= w_timer;
      r_shift     <= w_shift;
      r_idx       <= w_idx;
      r_hold      <= w_hold;
      r_hold_full <= w_hold_full;
      r_tx        <= w_tx;
      r_busy      <= w_busy;
      r_done      <= w_done;
`ifdef UART_TX_PARITY_EN
      r_par       <= w_par;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx with CLKS_PER_BIT=4.
// Honours UART_TX_PARITY_EN in the same way as the design.
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] d_i;
  logic       valid_i;
  logic       ready_o;
  logic       tx_o;
  logic       busy_o;
  logic       done_o;

  int unsigned n_checks;
  int unsigned n_errors;
  logic [7:0]  pend[$];
  logic [10:0] cap;

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .reset   (reset),
    .d_i     (d_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .tx_o    (tx_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected line level for bit number bi of a frame carrying b.
  function automatic logic exp_bit(input logic [7:0] b, input int bi);
    if (bi == 0) return 1'b0;
    if (bi <= 8) return b[bi-1];
`ifdef UART_TX_PARITY_EN
    if (bi == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // One clock: present the head of the byte queue, pop it if accepted.
  task automatic step();
    if (pend.size() > 0) begin
      valid_i = 1'b1;
      d_i     = pend[0];
    end else begin
      valid_i = 1'b0;
      d_i     = 8'($urandom);
    end
    if (valid_i && ready_o && !reset) void'(pend.pop_front());
    @(posedge clk);
    #1;
  endtask

  // Entered in the first start-bit cycle; leaves in the cycle after the stop bit.
  task automatic watch_frame(input logic [7:0] b, input logic first_done,
                             input int inj_k, input logic [7:0] inj_b,
                             output logic [10:0] bits);
    logic held;
    held = 1'b0;
    bits = '0;
    for (int k = 0; k < NB*CPB; k++) begin
      int bi;
      bi = k / CPB;
      check("tx", 32'(tx_o), 32'(exp_bit(b, bi)));
      check("busy", 32'(busy_o), 32'd1);
      check("done", 32'(done_o), (k == 0) ? 32'(first_done) : 32'd0);
      if (k == 0) check("ready_at_start", 32'(ready_o), 32'd1);
      else if (held) check("ready_held", 32'(ready_o), 32'd0);
      if (k % CPB == CPB/2) bits[bi] = tx_o;
      if (k == inj_k) begin
        pend.push_back(inj_b);
        held = 1'b1;
      end
      step();
    end
  endtask

  task automatic end_idle();
    check("end_done", 32'(done_o), 32'd1);
    check("end_busy", 32'(busy_o), 32'd0);
    check("end_tx", 32'(tx_o), 32'd1);
    check("end_ready", 32'(ready_o), 32'd1);
    step();
    check("idle_done", 32'(done_o), 32'd0);
    check("idle_tx", 32'(tx_o), 32'd1);
    step();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    valid_i  = 1'b0;
    d_i      = 8'h00;
    repeat (3) step();
    reset = 1'b0;
    check("rst_tx", 32'(tx_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd1);
    step();

    // Single frame 0xA5 from idle.
    pend.push_back(8'hA5);
    step();
    watch_frame(8'hA5, 1'b0, -1, 8'h00, cap);
`ifdef UART_TX_PARITY_EN
    check("a5_bits", 32'(cap), 32'h54A);
`else
    check("a5_bits", 32'(cap), 32'h34A);
`endif
    end_idle();

    // 0xFF queued while 0x3C is in DATA; second frame follows with no gap.
    pend.push_back(8'h3C);
    step();
    watch_frame(8'h3C, 1'b0, 10, 8'hFF, cap);
    watch_frame(8'hFF, 1'b1, -1, 8'h00, cap);
    end_idle();

    // valid_i held high across three bytes.
    pend.push_back(8'h00);
    pend.push_back(8'h55);
    pend.push_back(8'h81);
    step();
    watch_frame(8'h00, 1'b0, -1, 8'h00, cap);
    watch_frame(8'h55, 1'b1, -1, 8'h00, cap);
    watch_frame(8'h81, 1'b1, -1, 8'h00, cap);
    check("stream_drained", 32'(pend.size()), 32'd0);
    end_idle();

    // Reset in data bit 3 with a byte queued.
    pend.push_back(8'h96);
    step();
    pend.push_back(8'h3C);
    for (int k = 0; k < 17; k++) step();
    check("pre_rst_tx", 32'(tx_o), 32'd0);
    check("pre_rst_ready", 32'(ready_o), 32'd0);
    check("pre_rst_busy", 32'(busy_o), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_tx", 32'(tx_o), 32'd1);
    check("mid_rst_ready", 32'(ready_o), 32'd1);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_done", 32'(done_o), 32'd0);
    for (int k = 0; k < 2*NB*CPB; k++) begin
      check("post_rst_tx", 32'(tx_o), 32'd1);
      check("post_rst_done", 32'(done_o), 32'd0);
      check("post_rst_busy", 32'(busy_o), 32'd0);
      step();
    end
    pend.push_back(8'h5A);
    step();
    watch_frame(8'h5A, 1'b0, -1, 8'h00, cap);
    end_idle();

    // valid_i raised exactly in the last stop cycle: bypass, no idle cycle.
    pend.push_back(8'h12);
    step();
    watch_frame(8'h12, 1'b0, NB*CPB-1, 8'hC3, cap);
    watch_frame(8'hC3, 1'b1, -1, 8'h00, cap);
    end_idle();

    // 0x07 carries an odd number of ones.
    pend.push_back(8'h07);
    step();
    watch_frame(8'h07, 1'b0, -1, 8'h00, cap);
`ifdef UART_TX_PARITY_EN
    check("07_bits", 32'(cap), 32'h60E);
`else
    check("07_bits", 32'(cap), 32'h20E);
`endif
    end_idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
